// File: rtl/pu_pkg.sv
// Shared types and default sizes for the PU command sequencer slice.
package pu_pkg;

  localparam int DEF_WADDR_WIDTH = 7;
  localparam int DEF_RADDR_WIDTH = 6;
  localparam int DEF_CADDR_WIDTH = 5;
  localparam int DEF_KCNT_WIDTH  = 4;
  localparam int DEF_BADDR_WIDTH = 3;
  localparam int PU_PIPE_LAT     = 3;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    DRAIN,
    FIN
  } state_t;

endpackage

// File: rtl/pu_ctrl_if.sv
// Data handshake and PU command bus between pu_ctrl (master) and one PU (slave).
interface pu_ctrl_if
  import pu_pkg::*;
#(
  parameter int WADDR_WIDTH = DEF_WADDR_WIDTH,
  parameter int RADDR_WIDTH = DEF_RADDR_WIDTH,
  parameter int CADDR_WIDTH = DEF_CADDR_WIDTH,
  parameter int BADDR_WIDTH = DEF_BADDR_WIDTH
);

  logic                   in_data_valid;
  logic                   out_data_ready;
  logic                   out_add_bias;
  logic                   out_relu;
  logic                   out_done;
  logic                   out_cache_clear;
  logic [CADDR_WIDTH-1:0] out_cache_rd_addr;
  logic [CADDR_WIDTH-1:0] out_cache_wr_addr;
  logic [WADDR_WIDTH-1:0] out_w_rd_addr;
  logic [BADDR_WIDTH-1:0] out_bias_addr;
  logic                   out_r_wr_en;
  logic [RADDR_WIDTH-1:0] out_r_wr_addr;

  modport master (
    input  in_data_valid,
    output out_data_ready, out_add_bias, out_relu, out_done, out_cache_clear,
    output out_cache_rd_addr, out_cache_wr_addr, out_w_rd_addr, out_bias_addr,
    output out_r_wr_en, out_r_wr_addr
  );

  modport slave (
    output in_data_valid,
    input  out_data_ready, out_add_bias, out_relu, out_done, out_cache_clear,
    input  out_cache_rd_addr, out_cache_wr_addr, out_w_rd_addr, out_bias_addr,
    input  out_r_wr_en, out_r_wr_addr
  );

endinterface

// File: rtl/pu_wb_pipe.sv
// Fixed-latency valid+index shift register that delays done beats to rmem writeback.
module pu_wb_pipe #(
  parameter int LAT = 3,
  parameter int AW  = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [AW-1:0] push_n,
  output logic          pop_valid,
  output logic [AW-1:0] pop_n,
  output logic          pending
);

  logic [LAT-1:0] vld_q;
  logic [AW-1:0]  n_q [LAT];

  // Shift every stage by one each cycle; stage 0 takes the new entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < LAT; i++) n_q[i] <= '0;
    end else begin
      vld_q[0] <= push;
      n_q[0]   <= push_n;
      for (int unsigned i = 1; i < LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        n_q[i]   <= n_q[i-1];
      end
    end
  end

  // pending: some entry will still be in flight after this cycle's pop.
  always_comb begin
    pop_valid = vld_q[LAT-1];
    pop_n     = n_q[LAT-1];
    pending   = 1'b0;
    for (int unsigned i = 0; i + 1 < LAT; i++) pending = pending | vld_q[i];
  end

endmodule

// File: rtl/pu_ctrl.sv
// PU command sequencer for one fully-connected pass: walks (chunk k, output n),
// issues one PU beat per accepted data beat, retires sums to rmem after PIPE_LAT.
// Optional macro PU_CTRL_PERF_EN builds the RUN-cycle stall counter.
module pu_ctrl
  import pu_pkg::*;
#(
  parameter int WADDR_WIDTH = DEF_WADDR_WIDTH,
  parameter int RADDR_WIDTH = DEF_RADDR_WIDTH,
  parameter int CADDR_WIDTH = DEF_CADDR_WIDTH,
  parameter int KCNT_WIDTH  = DEF_KCNT_WIDTH,
  parameter int BADDR_WIDTH = DEF_BADDR_WIDTH,
  parameter int PIPE_LAT    = PU_PIPE_LAT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_start,
  input  logic [KCNT_WIDTH-1:0]  in_num_chunk_m1,
  input  logic [CADDR_WIDTH-1:0] in_num_out_m1,
  input  logic [WADDR_WIDTH-1:0] in_w_base,
  input  logic [RADDR_WIDTH-1:0] in_r_base,
  input  logic                   in_bias_en,
  input  logic                   in_relu_en,
  input  logic [BADDR_WIDTH-1:0] in_bias_base,
  output logic                   out_busy,
  output logic                   out_layer_done,
  output logic [15:0]            out_stall_cnt,
  pu_ctrl_if.master              pu
);

  state_t state_q, state_d;

  logic [KCNT_WIDTH-1:0]  k_q, k_max_q;
  logic [CADDR_WIDTH-1:0] n_q, n_max_q;
  logic [WADDR_WIDTH-1:0] w_ptr_q;
  logic [RADDR_WIDTH-1:0] r_base_q;
  logic [BADDR_WIDTH-1:0] bias_base_q;
  logic                   bias_en_q, relu_en_q;

  logic                   issue, last_k, last_n;
  logic                   wb_valid, wb_pending;
  logic [CADDR_WIDTH-1:0] wb_n;

  assign issue  = pu.in_data_valid & pu.out_data_ready;
  assign last_k = (k_q == k_max_q);
  assign last_n = (n_q == n_max_q);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: DRAIN leaves once no writeback remains after the current one.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_start) state_d = CLEAR;
      CLEAR:   state_d = RUN;
      RUN:     if (issue && last_k && last_n) state_d = DRAIN;
      DRAIN:   if (!wb_pending) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    pu.out_data_ready  = (state_q == RUN);
    pu.out_cache_clear = (state_q == CLEAR);
    out_busy           = (state_q == CLEAR) || (state_q == RUN) || (state_q == DRAIN);
    out_layer_done     = (state_q == FIN);
  end

  // Latch configuration on start; advance (k, n) and the running weight row per beat.
  // The weight row is an incrementing pointer: w_base + k*N + n steps by one per beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      k_q         <= '0;
      n_q         <= '0;
      k_max_q     <= '0;
      n_max_q     <= '0;
      w_ptr_q     <= '0;
      r_base_q    <= '0;
      bias_base_q <= '0;
      bias_en_q   <= 1'b0;
      relu_en_q   <= 1'b0;
    end else if (state_q == IDLE && in_start) begin
      k_q         <= '0;
      n_q         <= '0;
      k_max_q     <= in_num_chunk_m1;
      n_max_q     <= in_num_out_m1;
      w_ptr_q     <= in_w_base;
      r_base_q    <= in_r_base;
      bias_base_q <= in_bias_base;
      bias_en_q   <= in_bias_en;
      relu_en_q   <= in_relu_en;
    end else if (issue) begin
      w_ptr_q <= w_ptr_q + 1'b1;
      if (last_n) begin
        n_q <= '0;
        k_q <= k_q + 1'b1;
      end else begin
        n_q <= n_q + 1'b1;
      end
    end
  end

  // Register PU controls on issue so they line up with the captured data beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      pu.out_cache_rd_addr <= '0;
      pu.out_cache_wr_addr <= '0;
      pu.out_w_rd_addr     <= '0;
      pu.out_bias_addr     <= '0;
      pu.out_done          <= 1'b0;
      pu.out_add_bias      <= 1'b0;
      pu.out_relu          <= 1'b0;
    end else if (issue) begin
      pu.out_cache_rd_addr <= n_q;
      pu.out_cache_wr_addr <= n_q;
      pu.out_w_rd_addr     <= w_ptr_q;
      pu.out_bias_addr     <= bias_base_q;
      pu.out_done          <= last_k;
      pu.out_add_bias      <= last_k & bias_en_q;
      pu.out_relu          <= last_k & relu_en_q;
    end else begin
      pu.out_done     <= 1'b0;
      pu.out_add_bias <= 1'b0;
      pu.out_relu     <= 1'b0;
    end
  end

  pu_wb_pipe #(
    .LAT (PIPE_LAT),
    .AW  (CADDR_WIDTH)
  ) u_wb_pipe (
    .clk       (clk),
    .rst       (rst),
    .push      (issue & last_k),
    .push_n    (n_q),
    .pop_valid (wb_valid),
    .pop_n     (wb_n),
    .pending   (wb_pending)
  );

  // Retire finished sums into rmem at r_base + n.
  always_comb begin
    pu.out_r_wr_en   = wb_valid;
    pu.out_r_wr_addr = wb_valid ? RADDR_WIDTH'(r_base_q + RADDR_WIDTH'(wb_n)) : '0;
  end

`ifdef PU_CTRL_PERF_EN
  logic [15:0] stall_q;

  // Count RUN cycles starved of data; cleared on start, saturating.
  always_ff @(posedge clk) begin
    if (rst)                                stall_q <= '0;
    else if (state_q == IDLE && in_start)   stall_q <= '0;
    else if (state_q == RUN && !pu.in_data_valid && stall_q != '1)
                                            stall_q <= stall_q + 16'd1;
  end

  assign out_stall_cnt = stall_q;
`else
  assign out_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pu_ctrl.sv
// Directed bench for pu_ctrl: cycle tables for two full passes plus wrap,
// start-during-RUN and mid-RUN reset sequences.
module tb_pu_ctrl;

  logic        clk;
  logic        rst;
  logic        in_start;
  logic [3:0]  in_num_chunk_m1;
  logic [4:0]  in_num_out_m1;
  logic [6:0]  in_w_base;
  logic [5:0]  in_r_base;
  logic        in_bias_en;
  logic        in_relu_en;
  logic [2:0]  in_bias_base;
  logic        out_busy;
  logic        out_layer_done;
  logic [15:0] out_stall_cnt;

  pu_ctrl_if #(.WADDR_WIDTH(7), .RADDR_WIDTH(6), .CADDR_WIDTH(5), .BADDR_WIDTH(3)) pu_bus ();

  pu_ctrl #(
    .WADDR_WIDTH (7),
    .RADDR_WIDTH (6),
    .CADDR_WIDTH (5),
    .KCNT_WIDTH  (4),
    .BADDR_WIDTH (3),
    .PIPE_LAT    (3)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .in_start        (in_start),
    .in_num_chunk_m1 (in_num_chunk_m1),
    .in_num_out_m1   (in_num_out_m1),
    .in_w_base       (in_w_base),
    .in_r_base       (in_r_base),
    .in_bias_en      (in_bias_en),
    .in_relu_en      (in_relu_en),
    .in_bias_base    (in_bias_base),
    .out_busy        (out_busy),
    .out_layer_done  (out_layer_done),
    .out_stall_cnt   (out_stall_cnt),
    .pu              (pu_bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic start, valid;
    logic clr, rdy, busy, done, bias, relu;
    int   cache, w;
    logic ren;
    int   raddr;
    logic ld;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   got_w[$];
  int   got_r[$];
  int   n_relu, n_bias;
  bit   saw_ld;

  function automatic vec_t mk(logic start, logic valid, logic clr, logic rdy, logic busy,
                              logic done, logic bias, logic relu, int cache, int w,
                              logic ren, int raddr, logic ld);
    vec_t v;
    v.start = start; v.valid = valid; v.clr = clr; v.rdy = rdy; v.busy = busy;
    v.done = done; v.bias = bias; v.relu = relu; v.cache = cache; v.w = w;
    v.ren = ren; v.raddr = raddr; v.ld = ld;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; in_start = 1'b0; pu_bus.in_data_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic set_cfg(input int km1, input int nm1, input int wb, input int rb,
                         input bit be, input bit re, input int bb);
    in_num_chunk_m1 = 4'(km1); in_num_out_m1 = 5'(nm1);
    in_w_base = 7'(wb); in_r_base = 6'(rb);
    in_bias_en = be; in_relu_en = re; in_bias_base = 3'(bb);
  endtask

  function automatic int all_outs_or();
    return int'(|{pu_bus.out_data_ready, pu_bus.out_add_bias, pu_bus.out_relu,
                  pu_bus.out_done, pu_bus.out_cache_clear, pu_bus.out_cache_rd_addr,
                  pu_bus.out_cache_wr_addr, pu_bus.out_w_rd_addr, pu_bus.out_bias_addr,
                  pu_bus.out_r_wr_en, pu_bus.out_r_wr_addr, out_busy, out_layer_done,
                  out_stall_cnt});
  endfunction

  task automatic apply_vecs(input string tag);
    foreach (vecs[i]) begin
      in_start = vecs[i].start;
      pu_bus.in_data_valid = vecs[i].valid;
      @(posedge clk); #1;
      chk($sformatf("%s[%0d].clear", tag, i), pu_bus.out_cache_clear, vecs[i].clr);
      chk($sformatf("%s[%0d].ready", tag, i), pu_bus.out_data_ready, vecs[i].rdy);
      chk($sformatf("%s[%0d].busy", tag, i), out_busy, vecs[i].busy);
      chk($sformatf("%s[%0d].done", tag, i), pu_bus.out_done, vecs[i].done);
      chk($sformatf("%s[%0d].bias", tag, i), pu_bus.out_add_bias, vecs[i].bias);
      chk($sformatf("%s[%0d].relu", tag, i), pu_bus.out_relu, vecs[i].relu);
      chk($sformatf("%s[%0d].crd", tag, i), pu_bus.out_cache_rd_addr, vecs[i].cache);
      chk($sformatf("%s[%0d].cwr", tag, i), pu_bus.out_cache_wr_addr, vecs[i].cache);
      chk($sformatf("%s[%0d].waddr", tag, i), pu_bus.out_w_rd_addr, vecs[i].w);
      chk($sformatf("%s[%0d].rwen", tag, i), pu_bus.out_r_wr_en, vecs[i].ren);
      chk($sformatf("%s[%0d].raddr", tag, i), pu_bus.out_r_wr_addr, vecs[i].raddr);
      chk($sformatf("%s[%0d].ldone", tag, i), out_layer_done, vecs[i].ld);
    end
    in_start = 1'b0;
    pu_bus.in_data_valid = 1'b0;
  endtask

  // Start a pass with valid held high and record done beats / rmem writes until
  // layer_done or a cycle budget. With glitch set, a second start carrying a
  // different configuration is pulsed while RUN is issuing.
  task automatic run_collect(input bit glitch);
    got_w.delete(); got_r.delete();
    n_relu = 0; n_bias = 0; saw_ld = 0;
    in_start = 1'b1; pu_bus.in_data_valid = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < 60 && !saw_ld; c++) begin
      if (glitch && c == 3) begin
        in_start = 1'b1; in_w_base = 7'd50; in_num_out_m1 = 5'd0; in_r_base = 6'd30;
      end else begin
        in_start = 1'b0;
      end
      @(posedge clk); #1;
      if (pu_bus.out_done) got_w.push_back(int'(pu_bus.out_w_rd_addr));
      if (pu_bus.out_relu) n_relu++;
      if (pu_bus.out_add_bias) n_bias++;
      if (pu_bus.out_r_wr_en) got_r.push_back(int'(pu_bus.out_r_wr_addr));
      if (out_layer_done) saw_ld = 1;
    end
    in_start = 1'b0;
    pu_bus.in_data_valid = 1'b0;
    chk("collect.layer_done_seen", int'(saw_ld), 1);
  endtask

  task automatic chk_list(input string tag, input int got[$], input int exp[$]);
    chk({tag, ".count"}, got.size(), exp.size());
    foreach (exp[i]) chk($sformatf("%s[%0d]", tag, i), (i < got.size()) ? got[i] : -1, exp[i]);
  endtask

  initial begin
    int exp_w[$];
    int exp_r[$];
    int cnt;
    int stall_exp;

    set_cfg(0, 3, 0, 8, 0, 0, 0);
    do_reset();
    chk("reset.all_outputs_zero", all_outs_or(), 0);

    // K=1, N=4: every beat is a done beat; writes at 8..11.
    vecs.delete();
    vecs.push_back(mk(1,1, 1,0,1,0,0,0, 0,0, 0,0, 0));
    vecs.push_back(mk(0,1, 0,1,1,0,0,0, 0,0, 0,0, 0));
    vecs.push_back(mk(0,1, 0,1,1,1,0,0, 0,0, 0,0, 0));
    vecs.push_back(mk(0,1, 0,1,1,1,0,0, 1,1, 0,0, 0));
    vecs.push_back(mk(0,1, 0,1,1,1,0,0, 2,2, 1,8, 0));
    vecs.push_back(mk(0,1, 0,0,1,1,0,0, 3,3, 1,9, 0));
    vecs.push_back(mk(0,1, 0,0,1,0,0,0, 3,3, 1,10,0));
    vecs.push_back(mk(0,1, 0,0,1,0,0,0, 3,3, 1,11,0));
    vecs.push_back(mk(0,1, 0,0,0,0,0,0, 3,3, 0,0, 1));
    vecs.push_back(mk(0,1, 0,0,0,0,0,0, 3,3, 0,0, 0));
    apply_vecs("k1n4");

    // K=3, N=2, bias on, 3-cycle stall after the second beat.
    set_cfg(2, 1, 0, 20, 1, 0, 5);
    do_reset();
    vecs.delete();
    vecs.push_back(mk(1,0, 1,0,1,0,0,0, 0,0, 0,0, 0));
    vecs.push_back(mk(0,1, 0,1,1,0,0,0, 0,0, 0,0, 0));
    vecs.push_back(mk(0,1, 0,1,1,0,0,0, 0,0, 0,0, 0));
    vecs.push_back(mk(0,1, 0,1,1,0,0,0, 1,1, 0,0, 0));
    vecs.push_back(mk(0,0, 0,1,1,0,0,0, 1,1, 0,0, 0));
    vecs.push_back(mk(0,0, 0,1,1,0,0,0, 1,1, 0,0, 0));
    vecs.push_back(mk(0,0, 0,1,1,0,0,0, 1,1, 0,0, 0));
    vecs.push_back(mk(0,1, 0,1,1,0,0,0, 0,2, 0,0, 0));
    vecs.push_back(mk(0,1, 0,1,1,0,0,0, 1,3, 0,0, 0));
    vecs.push_back(mk(0,1, 0,1,1,1,1,0, 0,4, 0,0, 0));
    vecs.push_back(mk(0,1, 0,0,1,1,1,0, 1,5, 0,0, 0));
    vecs.push_back(mk(0,1, 0,0,1,0,0,0, 1,5, 1,20,0));
    vecs.push_back(mk(0,1, 0,0,1,0,0,0, 1,5, 1,21,0));
    vecs.push_back(mk(0,1, 0,0,0,0,0,0, 1,5, 0,0, 1));
    vecs.push_back(mk(0,0, 0,0,0,0,0,0, 1,5, 0,0, 0));
    apply_vecs("k3n2_stall");
    chk("k3n2.bias_addr", pu_bus.out_bias_addr, 5);
`ifdef PU_CTRL_PERF_EN
    stall_exp = 3;
`else
    stall_exp = 0;
`endif
    chk("k3n2.stall_cnt", out_stall_cnt, stall_exp);

    // Address wrap on both weight and result sides; bias/relu on every beat for K=1.
    set_cfg(0, 3, 126, 62, 1, 1, 2);
    do_reset();
    run_collect(1'b0);
    exp_w = '{126, 127, 0, 1};
    exp_r = '{62, 63, 0, 1};
    chk_list("wrap.w", got_w, exp_w);
    chk_list("wrap.r", got_r, exp_r);
    chk("wrap.relu_beats", n_relu, 4);
    chk("wrap.bias_beats", n_bias, 4);

    // Start pulsed mid-RUN with a different configuration is ignored.
    set_cfg(0, 3, 0, 8, 0, 0, 0);
    do_reset();
    run_collect(1'b1);
    exp_w = '{0, 1, 2, 3};
    exp_r = '{8, 9, 10, 11};
    chk_list("start_in_run.w", got_w, exp_w);
    chk_list("start_in_run.r", got_r, exp_r);
    set_cfg(0, 3, 0, 8, 0, 0, 0);

    // Reset mid-RUN aborts at once, no completion pulse; next pass is clean.
    do_reset();
    in_start = 1'b1; pu_bus.in_data_valid = 1'b1;
    @(posedge clk); #1;
    in_start = 1'b0;
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
    chk("rst_mid.busy_before", out_busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid.all_outputs_zero", all_outs_or(), 0);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_layer_done || out_busy || pu_bus.out_r_wr_en) cnt++;
    end
    chk("rst_mid.quiet_after", cnt, 0);
    run_collect(1'b0);
    chk_list("after_rst.w", got_w, exp_w);
    chk_list("after_rst.r", got_r, exp_r);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/pu_ctrl.md
Name: pu_ctrl

Overview:
- Sequencer that drives the command side of a PU: cache, weight-read, bias, ReLU, done and rmem-write controls for one fully-connected pass.
- Walks every (input chunk k, output n) pair, consumes one upstream data beat per pair, and retires finished sums into rmem after the PU pipeline latency.
- Sits between the layer scheduler (start/done) and one PU instance.

Parameters:
- WADDR_WIDTH, 7, wmem address width
- RADDR_WIDTH, 6, rmem address width
- CADDR_WIDTH, 5, PU partial-sum cache address width (max 2^CADDR_WIDTH outputs)
- KCNT_WIDTH, 4, chunk-count field width
- BADDR_WIDTH, 3, bias address width
- PIPE_LAT, 3, cycles from issuing the done beat to out_total_sum being valid at the PU

Ports:
- clk  in  1  clock
- rst  in  1  reset; single clock, synchronous, active-high
- in_start  in  1  start pulse; sampled only in IDLE
- in_num_chunk_m1  in  KCNT_WIDTH  K-1, number of input chunks minus one
- in_num_out_m1  in  CADDR_WIDTH  N-1, number of outputs minus one
- in_w_base  in  WADDR_WIDTH  first weight row
- in_r_base  in  RADDR_WIDTH  first rmem result address
- in_bias_en  in  1  add bias on the final chunk
- in_relu_en  in  1  apply ReLU on the final chunk
- in_bias_base  in  BADDR_WIDTH  bias address
- in_data_valid  in  1  upstream data beat available
- out_data_ready  out  1  beat consumed this cycle
- out_busy  out  1  high from start until FIN
- out_layer_done  out  1  one-cycle completion pulse
- out_add_bias, out_relu, out_done  out  1 each  to PU MAC cluster
- out_cache_clear  out  1  to PU
- out_cache_rd_addr, out_cache_wr_addr  out  CADDR_WIDTH  to PU
- out_w_rd_addr  out  WADDR_WIDTH  to PU wmem
- out_bias_addr  out  BADDR_WIDTH  to PU
- out_r_wr_en  out  1  to PU rmem
- out_r_wr_addr  out  RADDR_WIDTH  to PU rmem
- out_stall_cnt  out  16  see Optional Feature

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, writeback pipe cleared. Reset mid-operation aborts immediately; no out_layer_done pulse.
- FSM states: IDLE -> CLEAR -> RUN -> DRAIN -> FIN -> IDLE.
- IDLE: when in_start=1, latch all in_* configuration, set k=0 and n=0, go to CLEAR. in_start is ignored in every other state.
- CLEAR: out_cache_clear=1 for exactly one cycle, then RUN.
- RUN, beat issue:
  - out_data_ready = (state==RUN).
  - A beat issues when in_data_valid & out_data_ready.
  - On an issue cycle, all PU controls are registered so they are valid the following cycle, aligned with the data the PU captures.
  - out_cache_rd_addr = out_cache_wr_addr = n.
  - out_w_rd_addr = (w_base + k*(N) + n) mod 2^WADDR_WIDTH; wrap is silent.
  - out_done = out_add_bias = out_relu = 0 unless k==K-1. On the last chunk they equal 1, bias_en and relu_en respectively.
  - out_bias_addr = bias_base.
- RUN, no issue: with valid low, counters hold and out_done/out_add_bias/out_relu are forced to 0. Address outputs hold their last value.
- Counter advance: n increments; when n==N-1, n wraps to 0 and k increments. The beat with k==K-1 and n==N-1 moves the FSM to DRAIN.
- Writeback:
  - Each done beat pushes (n) into a PIPE_LAT-deep shift pipe.
  - PIPE_LAT cycles after the done beat, out_r_wr_en=1 for one cycle with out_r_wr_addr = (r_base + n) mod 2^RADDR_WIDTH.
  - Writebacks also occur during RUN, interleaved with issue.
- DRAIN: wait until the writeback pipe is empty, then FIN.
- FIN: out_layer_done=1 for one cycle, out_busy falls in the same cycle, return to IDLE.
- Degenerate case K=1: every beat is a done beat.
- Total issued beats = K*N. Total rmem writes = N.

Optional Feature:
- Macro PU_CTRL_PERF_EN.
- Defined: out_stall_cnt counts RUN cycles with in_data_valid=0. Cleared on accepted start, saturates at 16'hFFFF, holds its value after FIN.
- Undefined: out_stall_cnt is tied to 0 and no counter logic is built.

Decomposition:
- Shared package pu_pkg holds:
  - state enum {IDLE, CLEAR, RUN, DRAIN, FIN};
  - default widths (WADDR 7, RADDR 6, CADDR 5);
  - PIPE_LAT constant.
- One sub-module, pu_wb_pipe: a PIPE_LAT-stage valid+address shift register used for the writeback delay.

Test Plan:
- K=1, N=4, w_base=0, r_base=8, valid always 1 -> cache_clear 1 cycle; 4 beats with w addr 0..3 and out_done=1 on each; r_wr at 8..11, each PIPE_LAT cycles after its beat; layer_done one cycle after the last write.
- K=3, N=2, bias_en=1, relu_en=0 -> 6 beats with w addr 0,1,2,3,4,5; out_done and out_add_bias only on the beats with w addr 4 and 5; out_relu never 1; exactly 2 rmem writes.
- Stall: same as above with valid low for 3 cycles after the 2nd beat -> ready stays 1, counters hold, no spurious done; with PU_CTRL_PERF_EN, stall_cnt=3.
- Wrap: w_base=126, K=1, N=4 -> w addr 126,127,0,1; r_base=62 -> r addr 62,63,0,1.
- in_start pulsed during RUN -> ignored, configuration unchanged; rst asserted mid-RUN -> all outputs 0 next cycle, no layer_done, new start then runs cleanly.
